// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: control codes,
// sequencer state encoding and the legal-code check.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // True for the control codes the shared ALU actually implements.
  function automatic logic is_legal_ctrl(input logic [3:0] ctrl);
    case (ctrl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the
// requester that did not win last time is chosen. Purely combinational.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Grant selection from current valids and the previous winner.
  always_comb begin
    gnt_valid = |valid;
    gnt_id    = 1'b0;
    if (&valid) begin
      gnt_id = ~last_grant;
    end else if (valid[1]) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two valid/ready requesters. One operation is in
// flight at a time: grant, hold ALU inputs for LAT cycles, sample result
// and zero flag, then present a buffered response tagged with the id.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_op1,
  input  logic [DATA_W-1:0] r0_op2,
  input  logic [3:0]        r0_ctrl,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_op1,
  input  logic [DATA_W-1:0] r1_op2,
  input  logic [3:0]        r1_ctrl,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_zero,
  output logic              resp_err
);

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   alu_op1_q, alu_op1_d;
  logic [DATA_W-1:0]   alu_op2_q, alu_op2_d;
  logic [3:0]          alu_ctrl_q, alu_ctrl_d;
  logic                resp_id_q, resp_id_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_zero_q, resp_zero_d;
  logic                resp_err_q, resp_err_d;

  logic                gnt_valid, gnt_id;
  logic [DATA_W-1:0]   sel_op1, sel_op2;
  logic [3:0]          sel_ctrl;

  rr_arb2 u_arb (
    .valid      ({r1_valid, r0_valid}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Ready only while idle, to the granted requester; never to both.
  always_comb begin
    r0_ready = (state_q == IDLE) && gnt_valid && !gnt_id;
    r1_ready = (state_q == IDLE) && gnt_valid &&  gnt_id;
    sel_op1  = gnt_id ? r1_op1  : r0_op1;
    sel_op2  = gnt_id ? r1_op2  : r0_op2;
    sel_ctrl = gnt_id ? r1_ctrl : r0_ctrl;
  end

  // Sequencer next-state: accept, wait out the ALU latency, hold response.
  always_comb begin
    // NOTE: every *_d defaults to its flop first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    alu_ctrl_d   = alu_ctrl_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_zero_d  = resp_zero_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          resp_id_d    = gnt_id;
          last_grant_d = gnt_id;
          if (is_legal_ctrl(sel_ctrl)) begin
            alu_op1_d  = sel_op1;
            alu_op2_d  = sel_op2;
            alu_ctrl_d = sel_ctrl;
            cnt_d      = LAT_M1;
            state_d    = BUSY;
          end else begin
            // Illegal code: skip the ALU entirely and report an error.
            resp_err_d  = 1'b1;
            resp_data_d = '0;
            resp_zero_d = 1'b0;
            state_d     = RESP;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          resp_data_d = alu_out;
          resp_zero_d = alu_zero;
          resp_err_d  = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      alu_ctrl_q   <= ALU_AND;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_zero_q  <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values together.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      alu_ctrl_q   <= alu_ctrl_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_zero_q  <= resp_zero_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign alu_op1    = alu_op1_q;
  assign alu_op2    = alu_op2_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign resp_valid = (state_q == RESP);
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_zero  = resp_zero_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with a behavioural ALU and a
// transaction-level reference model (grant order, result, latency).
module tb_alu_share_ctrl;

  localparam int DATA_W = 64;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              r0_valid, r1_valid;
  logic              r0_ready, r1_ready;
  logic [DATA_W-1:0] r0_op1, r0_op2, r1_op1, r1_op2;
  logic [3:0]        r0_ctrl, r1_ctrl;
  logic [DATA_W-1:0] alu_op1, alu_op2, alu_out;
  logic [3:0]        alu_ctrl;
  logic              alu_zero;
  logic              resp_valid, resp_ready, resp_id, resp_zero, resp_err;
  logic [DATA_W-1:0] resp_data;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: who won last, and what the ALU input registers should hold.
  bit                exp_last;
  logic [DATA_W-1:0] held_op1, held_op2;
  logic [3:0]        held_ctrl;

  always #5 clk = ~clk;

  alu_share_ctrl #(.DATA_W(DATA_W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op1(r0_op1),
    .r0_op2(r0_op2), .r0_ctrl(r0_ctrl),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op1(r1_op1),
    .r1_op2(r1_op2), .r1_ctrl(r1_ctrl),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err)
  );

  function automatic logic [DATA_W-1:0] ref_alu(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      default: return '0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [3:0] c);
    return (c == 4'b0000) || (c == 4'b0001) || (c == 4'b0010) ||
           (c == 4'b0110) || (c == 4'b0111);
  endfunction

  // Behavioural ALU attached to the controller's ALU port.
  always_comb begin
    alu_out  = ref_alu(alu_op1, alu_op2, alu_ctrl);
    alu_zero = (alu_out == '0);
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check("ready_onehot", 64'(r0_ready & r1_ready), 64'd0);
  endtask

  // One transaction from whatever valids are driven now. keep: granted
  // requester keeps valid after acceptance. hold: cycles of resp back-pressure.
  task automatic run_txn(input bit keep, input int hold);
    bit                exp_id;
    bit                legal;
    logic [DATA_W-1:0] a, b, exp_data;
    logic [3:0]        c;
    logic [DATA_W-1:0] s_data;
    logic              s_id, s_zero, s_err;
    int                n;

    exp_id = (r0_valid && r1_valid) ? ~exp_last : r1_valid;
    #1;
    check("grant_r0_ready", 64'(r0_ready), 64'(!exp_id));
    check("grant_r1_ready", 64'(r1_ready), 64'(exp_id));
    a     = exp_id ? r1_op1 : r0_op1;
    b     = exp_id ? r1_op2 : r0_op2;
    c     = exp_id ? r1_ctrl : r0_ctrl;
    legal = ref_legal(c);
    exp_last = exp_id;
    if (legal) begin
      held_op1  = a;
      held_op2  = b;
      held_ctrl = c;
    end
    exp_data = legal ? ref_alu(a, b, c) : '0;

    step();  // acceptance edge
    if (!keep) begin
      if (exp_id) r1_valid = 1'b0;
      else        r0_valid = 1'b0;
    end
    #1;

    n = 0;
    while (!resp_valid && n < 20) begin
      check("busy_alu_ctrl", 64'(alu_ctrl), 64'(held_ctrl));
      check("busy_no_ready", 64'(r0_ready | r1_ready), 64'd0);
      step();
      n++;
    end
    check("resp_latency", 64'(n), legal ? 64'(LAT) : 64'd0);
    check("alu_op1", alu_op1, held_op1);
    check("alu_op2", alu_op2, held_op2);
    check("alu_ctrl", 64'(alu_ctrl), 64'(held_ctrl));
    check("resp_id", 64'(resp_id), 64'(exp_id));
    check("resp_data", resp_data, exp_data);
    check("resp_zero", 64'(resp_zero), legal ? 64'(exp_data == '0) : 64'd0);
    check("resp_err", 64'(resp_err), 64'(!legal));

    s_data = resp_data; s_id = resp_id; s_zero = resp_zero; s_err = resp_err;
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_data", resp_data, s_data);
      check("hold_flags", {61'd0, resp_id, resp_zero, resp_err},
            {61'd0, s_id, s_zero, s_err});
      check("hold_no_ready", 64'(r0_ready | r1_ready), 64'd0);
    end

    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("resp_taken", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; resp_ready = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_op1 = '0; r0_op2 = '0; r0_ctrl = '0;
    r1_op1 = '0; r1_op2 = '0; r1_ctrl = '0;
    exp_last = 1'b1; held_op1 = '0; held_op2 = '0; held_ctrl = 4'b0000;
    #12;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_alu_op1", alu_op1, 64'd0);
    check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_flags", {61'd0, resp_id, resp_zero, resp_err}, 64'd0);
    rst_n = 1'b1;
    step();

    // r0 ADD 5+7
    r0_valid = 1'b1; r0_op1 = 64'd5; r0_op2 = 64'd7; r0_ctrl = 4'b0010;
    run_txn(1'b0, 0);
    check("add_result_const", resp_data, 64'd12);

    // r1 SUB 9-9 -> zero
    r1_valid = 1'b1; r1_op1 = 64'd9; r1_op2 = 64'd9; r1_ctrl = 4'b0110;
    run_txn(1'b0, 0);

    // Both valid continuously: grants alternate.
    r0_valid = 1'b1; r0_op1 = 64'hF0; r0_op2 = 64'h3C; r0_ctrl = 4'b0000;
    r1_valid = 1'b1; r1_op1 = 64'hF0; r1_op2 = 64'h0F; r1_ctrl = 4'b0001;
    for (int i = 0; i < 4; i++) run_txn(1'b1, 0);
    r0_valid = 1'b0; r1_valid = 1'b0;

    // Illegal control code.
    r0_valid = 1'b1; r0_ctrl = 4'b1111; r0_op1 = 64'hDEAD; r0_op2 = 64'hBEEF;
    run_txn(1'b0, 0);

    // Back-pressure while r1 waits.
    r0_valid = 1'b1; r0_ctrl = 4'b0111; r0_op1 = 64'd1; r0_op2 = 64'h1234;
    r1_valid = 1'b1; r1_ctrl = 4'b0010; r1_op1 = 64'd3; r1_op2 = 64'd4;
    run_txn(1'b0, 5);
    run_txn(1'b0, 0);

    // Reset during BUSY.
    r1_valid = 1'b1; r1_ctrl = 4'b0010; r1_op1 = 64'd100; r1_op2 = 64'd1;
    #1;
    step();            // accepted
    r1_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_alu_op1", alu_op1, 64'd0);
    check("mid_rst_alu_op2", alu_op2, 64'd0);
    check("mid_rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    check("mid_rst_resp", {resp_data[60:0], resp_id, resp_zero, resp_err}, 64'd0);
    step();
    rst_n = 1'b1;
    exp_last = 1'b1; held_op1 = '0; held_op2 = '0; held_ctrl = 4'b0000;
    step();
    r0_valid = 1'b1; r0_ctrl = 4'b0001; r0_op1 = 64'h5; r0_op2 = 64'hA;
    r1_valid = 1'b1; r1_ctrl = 4'b0110; r1_op1 = 64'h5; r1_op2 = 64'h6;
    run_txn(1'b0, 0);  // r0 must win the tie
    run_txn(1'b0, 0);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      int mode;
      logic [3:0] codes [8];
      codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                4'b0011, 4'b1000, 4'b1111};
      mode = $urandom_range(0, 2);
      r0_op1 = {$urandom, $urandom}; r0_op2 = {$urandom, $urandom};
      r1_op1 = {$urandom, $urandom}; r1_op2 = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) r0_op2 = r0_op1;
      if ($urandom_range(0, 3) == 0) r1_op2 = r1_op1;
      r0_ctrl = codes[$urandom_range(0, 7)];
      r1_ctrl = codes[$urandom_range(0, 7)];
      r0_valid = (mode != 1);
      r1_valid = (mode != 0);
      run_txn(1'b0, int'($urandom_range(0, 2)));
      r0_valid = 1'b0; r1_valid = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
